ise_rank_engine: RTL

- Parametrised successor to the fixed 32-image/128x128 image sorting engine.
- Accepts a stream of RGB pixels grouped into images and classifies each image by its dominant colour.
- After a full frame of images, emits every image index in ranked order, one per cycle.
- Adds configurable image count, image size, channel width, ranking direction and a per-image key output.

---
 rtl/ise_rank_engine_if.sv | 29 ++
 rtl/ise_rank_engine.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/ise_rank_engine_if.sv
// Pixel-in / ranked-out bus of the image rank engine.
// Widths are derived from the same frame parameters as the engine.
interface ise_rank_engine_if #(
  parameter int IMG_NUM = 32,
  parameter int IMG_PIX = 16384,
  parameter int CH_W    = 8
);
  localparam int IDX_W = $clog2(IMG_NUM);
  localparam int CNT_W = $clog2(IMG_PIX + 1);

  logic                 in_valid;
  logic [IDX_W-1:0]     image_in_index;
  logic [3*CH_W-1:0]    pixel_in;
  logic                 busy;
  logic                 out_valid;
  logic [1:0]           color_index;
  logic [IDX_W-1:0]     image_out_index;
  logic [CNT_W-1:0]     out_key;

  modport master (
    output in_valid, image_in_index, pixel_in,
    input  busy, out_valid, color_index, image_out_index, out_key
  );

  modport slave (
    input  in_valid, image_in_index, pixel_in,
    output busy, out_valid, color_index, image_out_index, out_key
  );
endinterface

// File: rtl/ise_rank_engine.sv
// Classifies each image of a frame by its dominant colour, then streams
// all image indices out in rank order (class, key, index), one per cycle.
module ise_rank_engine #(
  parameter int IMG_NUM = 32,
  parameter int IMG_PIX = 16384,
  parameter int CH_W    = 8,
  parameter int MODE    = 0
) (
  input logic clk,
  input logic reset,
  ise_rank_engine_if.slave bus
);
  localparam int IDX_W = $clog2(IMG_NUM);
  localparam int CNT_W = $clog2(IMG_PIX + 1);
  localparam int RK_W  = 2 + CNT_W + IDX_W;
  localparam logic [CNT_W-1:0] PIX_LAST = CNT_W'(IMG_PIX - 1);
  localparam logic [IDX_W:0]   IMG_LAST = (IDX_W + 1)'(IMG_NUM - 1);

  typedef enum logic [1:0] {ACCUM, CLASS, OUT} state_t;

  state_t                          state;
  logic [CNT_W-1:0]                pix_cnt, cnt_r, cnt_g, cnt_b;
  logic [IDX_W-1:0]                cur_idx;
  logic [IDX_W:0]                  img_cnt;
  logic [IMG_NUM-1:0][1:0]         tbl_cls;
  logic [IMG_NUM-1:0][CNT_W-1:0]   tbl_key;
  logic [IMG_NUM-1:0]              tbl_vld, picked, cand;
  logic [IMG_NUM-1:0][RK_W-1:0]    rank;

  logic [CH_W-1:0] pr, pg, pb;
  logic            is_r, is_g;
  logic [1:0]      cls_w;
  logic [CNT_W-1:0] key_w;
  logic            sel_hit;
  logic [RK_W-1:0] sel_rk;
  logic [IDX_W-1:0] sel_idx;

  assign {pr, pg, pb} = bus.pixel_in;
  assign is_r = (pr >= pg) && (pr >= pb);
  assign is_g = !is_r && (pg >= pb);

  always_comb begin
    cls_w = 2'd2;
    key_w = cnt_b;
    if (cnt_r >= cnt_g && cnt_r >= cnt_b) begin
      cls_w = 2'd0;
      key_w = cnt_r;
    end else if (cnt_g >= cnt_b) begin
      cls_w = 2'd1;
      key_w = cnt_g;
    end
  end

  // Rank word: smaller is better. Key is inverted for descending order so a
  // single unsigned minimum covers class, key and index tie-break at once.
  for (genvar i = 0; i < IMG_NUM; i++) begin : g_rank
    if (MODE == 0) begin : g_desc
      assign rank[i] = {tbl_cls[i], ~tbl_key[i], IDX_W'(i)};
    end else begin : g_asc
      assign rank[i] = {tbl_cls[i], tbl_key[i], IDX_W'(i)};
    end
    assign cand[i] = tbl_vld[i] & ~picked[i];
  end

  always_comb begin
    sel_hit = 1'b0;
    sel_rk  = '1;
    sel_idx = '0;
    for (int i = 0; i < IMG_NUM; i++) begin
      if (cand[i] && (!sel_hit || rank[i] < sel_rk)) begin
        sel_hit = 1'b1;
        sel_rk  = rank[i];
        sel_idx = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state               <= ACCUM;
      pix_cnt             <= '0;
      cnt_r               <= '0;
      cnt_g               <= '0;
      cnt_b               <= '0;
      cur_idx             <= '0;
      img_cnt             <= '0;
      tbl_cls             <= '0;
      tbl_key             <= '0;
      tbl_vld             <= '0;
      picked              <= '0;
      bus.busy            <= 1'b0;
      bus.out_valid       <= 1'b0;
      bus.color_index     <= '0;
      bus.image_out_index <= '0;
      bus.out_key         <= '0;
    end else begin
      bus.out_valid <= 1'b0;
      case (state)
        ACCUM: if (bus.in_valid) begin
          if (pix_cnt == '0) cur_idx <= bus.image_in_index;
          if (is_r)      cnt_r <= cnt_r + 1'b1;
          else if (is_g) cnt_g <= cnt_g + 1'b1;
          else           cnt_b <= cnt_b + 1'b1;
          if (pix_cnt == PIX_LAST) begin
            pix_cnt  <= '0;
            state    <= CLASS;
            bus.busy <= 1'b1;
          end else begin
            pix_cnt <= pix_cnt + 1'b1;
          end
        end
        CLASS: begin
          tbl_cls[cur_idx] <= cls_w;
          tbl_key[cur_idx] <= key_w;
          tbl_vld[cur_idx] <= 1'b1;
          cnt_r <= '0;
          cnt_g <= '0;
          cnt_b <= '0;
          if (img_cnt == IMG_LAST) begin
            img_cnt <= '0;
            state   <= OUT;
          end else begin
            img_cnt  <= img_cnt + 1'b1;
            state    <= ACCUM;
            bus.busy <= 1'b0;
          end
        end
        OUT: begin
          bus.out_valid       <= 1'b1;
          bus.color_index     <= tbl_cls[sel_idx];
          bus.image_out_index <= sel_idx;
          bus.out_key         <= tbl_key[sel_idx];
          picked[sel_idx]     <= 1'b1;
          if (img_cnt == IMG_LAST) begin
            // frame drained: free the table for the next frame
            img_cnt  <= '0;
            state    <= ACCUM;
            bus.busy <= 1'b0;
            tbl_vld  <= '0;
            picked   <= '0;
          end else begin
            img_cnt <= img_cnt + 1'b1;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end
endmodule
